// File: rtl/ins_decode.sv
// Instruction decode stage: decodes each fetched word on entry into a 2-entry in-order FIFO
// and presents the head entry to execute. Supports flush, back-pressure and a saturating hand-off count.
module ins_decode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [19:0]      ins,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       opcode,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [3:0]       rt,
    output logic [3:0]       funct,
    output logic [19:0]      extend,
    output logic             br,
    output logic             reg_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             alu_src,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_cnt
);

    localparam int DATA_W = 20;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [3:0]        rd;
        logic [3:0]        rs;
        logic [3:0]        rt;
        logic [3:0]        funct;
        logic [DATA_W-1:0] extend;
        logic              br;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic              alu_src;
        logic              illegal;
    } bundle_t;

    function automatic bundle_t decode(input logic [DATA_W-1:0] w);
        bundle_t                  b;
        logic signed [7:0]        imm;
        logic signed [DATA_W-1:0] ext;
        b        = '0;
        b.opcode = w[19:16];
        b.rd     = w[15:12];
        b.rs     = w[11:8];
        b.rt     = w[7:4];
        b.funct  = w[3:0];
        imm      = w[7:0];
        ext      = imm;
        b.extend = ext;
        case (w[19:16])
            4'h0: b.reg_wr = 1'b1;
            4'h1: begin b.reg_wr = 1'b1; b.alu_src = 1'b1; end
            4'h2: begin b.reg_wr = 1'b1; b.mem_rd = 1'b1; b.alu_src = 1'b1; end
            4'h3: begin b.mem_wr = 1'b1; b.alu_src = 1'b1; end
            4'h4: b.br = 1'b1;
            default: b.illegal = 1'b1;
        endcase
        return b;
    endfunction

    logic [1:0] ent_p1;
    logic       wr_ptr_p1;
    logic       rd_ptr_p1;
    bundle_t    fifo_p1 [2];
    bundle_t    dec_p0;
    bundle_t    out_b;
    logic       enq;
    logic       deq;

    assign in_ready  = ~ent_p1[1];
    assign out_valid = |ent_p1;
    assign enq       = in_valid & in_ready & ~flush;
    assign deq       = out_valid & out_ready & ~flush;
    assign dec_p0    = decode(ins);

    // p0 -> p1: decoded bundle enters the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            dec_cnt   <= '0;
        end else if (flush) begin
            ent_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
        end else begin
            if (enq) wr_ptr_p1 <= ~wr_ptr_p1;
            if (deq) rd_ptr_p1 <= ~rd_ptr_p1;
            case ({enq, deq})
                2'b10:   ent_p1 <= ent_p1 + 2'd1;
                2'b01:   ent_p1 <= ent_p1 - 2'd1;
                default: ;
            endcase
            if (deq && dec_cnt != '1) dec_cnt <= dec_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo_p1[wr_ptr_p1] <= dec_p0;
    end

    // p1 -> out: head entry, forced to zero while empty so stale data never leaks
    assign out_b   = out_valid ? fifo_p1[rd_ptr_p1] : '0;
    assign opcode  = out_b.opcode;
    assign rd      = out_b.rd;
    assign rs      = out_b.rs;
    assign rt      = out_b.rt;
    assign funct   = out_b.funct;
    assign extend  = out_b.extend;
    assign br      = out_b.br;
    assign reg_wr  = out_b.reg_wr;
    assign mem_rd  = out_b.mem_rd;
    assign mem_wr  = out_b.mem_wr;
    assign alu_src = out_b.alu_src;
    assign illegal = out_b.illegal;

endmodule

// File: doc/ins_decode.md
INS_DECODE -- requirements
Module: ins_decode

Interface
REQ-001 Parameter: CNT_W, default 16, width of the decoded-instruction counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  fetch stage presents an instruction word.
REQ-006 ins  input  20  instruction word from fetch.
REQ-007 in_ready  output  1  decode can accept a word this cycle.
REQ-008 flush  input  1  branch taken in execute; discard all buffered words.
REQ-009 out_valid  output  1  head entry holds a decoded instruction.
REQ-010 out_ready  input  1  execute consumes the head entry this cycle.
REQ-011 opcode / rd / rs / rt / funct  output  4 each  fields ins[19:16] / [15:12] / [11:8] / [7:4] / [3:0].
REQ-012 extend  output  20  ins[7:0] sign-extended to 20 bits.
REQ-013 br  output  1  instruction is BEQ.
REQ-014 reg_wr / mem_rd / mem_wr / alu_src  output  1 each  control bits.
REQ-015 illegal  output  1  head entry held an unsupported opcode.
REQ-016 dec_cnt  output  CNT_W  count of instructions handed to execute.

Function
REQ-017 Storage is a 2-entry in-order FIFO of decoded bundles; decode is done at enqueue; all out_* come from the head entry.
REQ-018 Enqueue occurs on a clk edge with in_valid=1 and in_ready=1; dequeue occurs on a clk edge with out_valid=1 and out_ready=1.
REQ-019 in_ready = (entries < 2); it depends only on registered state, never combinationally on out_ready.
REQ-020 out_valid = (entries > 0).
REQ-021 Latency: a word enqueued into an empty FIFO at edge N is visible with out_valid=1 in the cycle after edge N.
REQ-022 Simultaneous enqueue and dequeue with entries=1: the count stays 1 and the new word becomes head.
REQ-023 Full (entries=2): in_valid is ignored, and no entry is overwritten.
REQ-024 Empty: out_ready is ignored; decode outputs hold 0.
REQ-025 Opcode map:
  - 0x0 R-type: reg_wr=1.
  - 0x1 ADDI: reg_wr=1, alu_src=1.
  - 0x2 LW: reg_wr=1, mem_rd=1, alu_src=1.
  - 0x3 SW: mem_wr=1, alu_src=1.
  - 0x4 BEQ: br=1.
  - All other opcodes: every control bit 0 and illegal=1; the entry still flows as a normal FIFO entry.
REQ-026 extend[19:8] = ins[7] replicated; extend[7:0] = ins[7:0], for every opcode.
REQ-027 flush=1 at an edge empties the FIFO: entries becomes 0 and out_valid=0 next cycle. Any same-edge enqueue is dropped, and any same-edge dequeue is not counted.
REQ-028 dec_cnt increments by 1 per dequeue and saturates at all-ones (no wrap-around). flush does not clear it.
REQ-029 FIFO pointers wrap modulo 2; ordering is strictly first-in first-out.

Reset
REQ-030 While rst_n=0:
  - entries=0, out_valid=0, in_ready=1 (derived from entries=0), dec_cnt=0.
  - All decode outputs are 0.
REQ-031 Reset asserted mid-operation discards buffered words immediately (asynchronously). The first enqueue is possible at the first rising clk edge after rst_n rises.

Verification
REQ-032 Single-word latency: after reset, ins=0x2_3_1_05 (LW) with in_valid=1 for one cycle and out_ready=0 -> next cycle out_valid=1, opcode=2, rd=3, rs=1, extend=0x00005, reg_wr=1, mem_rd=1, alu_src=1.
REQ-033 Fill and backpressure: three consecutive valid words with out_ready=0 -> in_ready=0 after the second; the third is held upstream. Then out_ready=1 -> words emerge in order, and dec_cnt=3 after all three.
REQ-034 BEQ sign extension: ins=0x4_1_2_F8 -> br=1, extend=0xFFFF8. ins=0x4_1_2_7F -> extend=0x0007F.
REQ-035 Flush collision: entries=2, flush=1 with in_valid=1 and out_ready=1 on the same edge -> next cycle out_valid=0, in_ready=1, dec_cnt unchanged.
REQ-036 Illegal opcode: ins=0xA0000 -> illegal=1, all control bits 0, dequeues normally, and dec_cnt increments.
REQ-037 Counter saturation and async reset: with CNT_W=4, 20 dequeues -> dec_cnt=0xF. Then rst_n pulled low mid-cycle -> out_valid=0 and dec_cnt=0 before the next clk edge.
